// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer owning the HI/LO registers (32-step shift-add / restoring divide).
// Define SIGNED_MULDIV_EN to make op[1] select signed operation with sign fix-up at write-back.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_wb;
  logic [WIDTH-1:0]   quot_wb, rem_wb;
  logic               last_iter;

`ifdef SIGNED_MULDIV_EN
  logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

  always_comb begin
    a_mag = (op[1] && a[WIDTH-1]) ? -a : a;
    b_mag = (op[1] && b[WIDTH-1]) ? -b : b;
  end
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign a_mag = a;
  assign b_mag = b;
`endif

  // One iteration of each engine, computed from the current accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = div_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
    div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  end

  // Write-back values; b==0 in the engine naturally yields quotient=all-ones, remainder=dividend.
  always_comb begin
    prod_wb = mul_next;
    quot_wb = div_next[WIDTH-1:0];
    rem_wb  = div_next[2*WIDTH-1:WIDTH];
`ifdef SIGNED_MULDIV_EN
    if (neg_res_q) begin
      prod_wb = -mul_next;
      if (!div0_q) quot_wb = -div_next[WIDTH-1:0];
    end
    if (neg_rem_q) rem_wb = -div_next[2*WIDTH-1:WIDTH];
`endif
  end

  assign last_iter = (count_q == CW'(WIDTH - 1));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
`ifdef SIGNED_MULDIV_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        if (start && !cancel) begin
          state_d = op[0] ? S_DIV : S_MUL;
          count_d = '0;
          opnd_d  = op[0] ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, op[0] ? a_mag : b_mag};
`ifdef SIGNED_MULDIV_EN
          neg_res_d = op[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = op[1] && a[WIDTH-1];
          div0_d    = (b == '0);
`endif
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next;
          if (last_iter) begin
            {hi_d, lo_d} = prod_wb;
            state_d      = S_DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          if (last_iter) begin
            hi_d    = rem_wb;
            lo_d    = quot_wb;
            state_d = S_DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: engine datapath is fully loaded on every start, so it carries no reset.
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
`ifdef SIGNED_MULDIV_EN
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
`endif
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == S_MUL) || (state_q == S_DIV);
  assign done  = (state_q == S_DONE);
  assign stall = hilo_rd && busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops vs an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n, start, cancel, mthi_we, mtlo_we, hilo_rd;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  logic        busy, done, stall;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hilo_rd(hilo_rd), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    int          sx, sy;
    longint      sp;
    sx = x;
    sy = y;
`ifdef SIGNED_MULDIV_EN
    if (o[1]) begin
      if (!o[0]) begin
        sp = longint'(sx) * longint'(sy);
        {eh, el} = sp;
      end else if (y == 0) begin
        el = 32'hFFFF_FFFF; eh = x;
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        el = 32'h8000_0000; eh = 32'h0;
      end else begin
        el = sx / sy; eh = sx % sy;
      end
      return;
    end
`endif
    if (!o[0]) begin
      p = 64'(x) * 64'(y);
      {eh, el} = p;
    end else if (y == 0) begin
      el = 32'hFFFF_FFFF; eh = x;
    end else begin
      el = x / y; eh = x % y;
    end
  endtask

  // Launches an op (from IDLE or DONE) and returns sitting in the DONE cycle.
  // interfere: mid-op mthi_we and start, which must both be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit interfere);
    logic [31:0] eh, el;
    int n, bad_busy, bad_stall;
    model(o, x, y, eh, el);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    check({tag, "_busy0"}, 64'(busy), 64'd1);
    n = 0; bad_busy = 0; bad_stall = 0;
    while (!done && n < 40) begin
      if (!busy) bad_busy++;
      if (stall !== (hilo_rd && busy)) bad_stall++;
      if (interfere && n == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
        mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      tick();
      start = 1'b0; mthi_we = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_busyheld"}, 64'(bad_busy), 64'd0);
    check({tag, "_stall"}, 64'(bad_stall), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
    check({tag, "_done_nobusy"}, {62'd0, busy, stall}, 64'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    int          bad_done, r;
    reset_n = 1'b0; start = 1'b0; cancel = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    hilo_rd = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
    tick(); tick();
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, stall}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Basic multiply, single-cycle done pulse
    run_op("multu7x6", 2'b00, 32'd7, 32'd6, 1'b0);
    tick();
    check("done_pulse", {62'd0, done, busy}, 64'd0);
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("divu100_7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("divu5_0", 2'b01, 32'd5, 32'd0, 1'b0);
    tick();

    // Preload and cancel mid-op
    mthi_we = 1'b1; wdata = 32'h1234; tick(); mthi_we = 1'b0;
    mtlo_we = 1'b1; wdata = 32'h5678; tick(); mtlo_we = 1'b0;
    check("preload", {hi, lo}, {32'h1234, 32'h5678});
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("cancel_idle", {62'd0, busy, done}, 64'd0);
    check("cancel_hilo", {hi, lo}, {32'h1234, 32'h5678});
    bad_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) bad_done++;
      tick();
    end
    check("cancel_nodone", 64'(bad_done), 64'd0);

    // cancel in IDLE blocks start; mthi/mtlo together with start land first
    cancel = 1'b1; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3; tick();
    cancel = 1'b0; start = 1'b0;
    check("cancel_blocks_start", 64'(busy), 64'd0);
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hCAFE_0001;
    op = 2'b01; a = 32'd50; b = 32'd8; start = 1'b1; tick();
    start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    check("write_with_start", {hi, lo}, {32'hCAFE_0001, 32'hCAFE_0001});
    n_tests += 0;
    r = 0;
    while (!done && r < 40) begin tick(); r++; end
    check("write_then_result", {hi, lo}, {32'd2, 32'd6});

    // Interference while busy, with hilo_rd held
    hilo_rd = 1'b1;
    run_op("interfere", 2'b00, 32'd7, 32'd6, 1'b1);
    hilo_rd = 1'b0;

    // Signed-selected cases; model decides per build
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("mult_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op("div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_s0", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Random ops, chained back-to-back from DONE
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      r = $urandom_range(0, 7);
      case (r)
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: y = 32'hFFFF_FFFF;
        3: y = 32'h8000_0000;
        default: y = $urandom;
      endcase
      if (r == 4) x = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), 2'($urandom), x, y, 1'b0);
    end

    // Reset mid-op
    op = 2'b00; a = 32'd11; b = 32'd13; start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("reset_midop_hilo", {hi, lo}, 64'd0);
    check("reset_midop_flags", {62'd0, busy, done}, 64'd0);
    tick();
    check("reset_stays_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
